// File: rtl/ps2_host_transmitter.sv
// Host-to-device PS/2 command sender using the open-drain request-to-send sequence, clocked by the device's clock.
// Latency: data_oe follows a device clock fall by 2 + FILTER_LEN + 1 cycles; backpressure: tx_ready is low from acceptance until the return to IDLE.
module ps2_host_transmitter #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int REQ_CYCLES     = 250,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       ps2_busy
);

    localparam int PHASE_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
    localparam int PW = $clog2(PHASE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FW = $clog2(FILTER_LEN + 1);

    localparam logic [PW-1:0] INHIBIT_LAST = PW'(INHIBIT_CYCLES - 1);
    localparam logic [PW-1:0] REQ_LAST     = PW'(REQ_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [FW-1:0] FILTER_LAST  = FW'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        WAIT_IDLE
    } state_t;

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_s;
    logic          data_s;
    logic [FW-1:0] filter_cnt;
    logic          ps2_clk_filtered;
    logic          fall;

    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
        end
    end

    // The filtered clock only flips after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            filter_cnt       <= '0;
            ps2_clk_filtered <= 1'b1;
            fall             <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_s == ps2_clk_filtered) begin
                filter_cnt <= '0;
            end else if (filter_cnt == FILTER_LAST) begin
                filter_cnt       <= '0;
                ps2_clk_filtered <= clk_s;
                fall             <= ~clk_s;
            end else begin
                filter_cnt <= filter_cnt + FW'(1);
            end
        end
    end

    state_t        state, state_d;
    logic [9:0]    frame, frame_d;
    logic [3:0]    bitcnt, bitcnt_d;
    logic [PW-1:0] phase_cnt, phase_d;
    logic [TW-1:0] timeout_cnt, timeout_d;
    logic          ack_ok, ack_ok_d;
    logic          clk_oe_d, data_oe_d, done_d, error_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            frame       <= '0;
            bitcnt      <= '0;
            phase_cnt   <= '0;
            timeout_cnt <= '0;
            ack_ok      <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_ready    <= 1'b1;
            tx_done     <= 1'b0;
            tx_error    <= 1'b0;
            ps2_busy    <= 1'b0;
        end else begin
            state       <= state_d;
            frame       <= frame_d;
            bitcnt      <= bitcnt_d;
            phase_cnt   <= phase_d;
            timeout_cnt <= timeout_d;
            ack_ok      <= ack_ok_d;
            ps2_clk_oe  <= clk_oe_d;
            ps2_data_oe <= data_oe_d;
            tx_ready    <= (state_d == IDLE);
            tx_done     <= done_d;
            tx_error    <= error_d;
            ps2_busy    <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d   = state;
        frame_d   = frame;
        bitcnt_d  = bitcnt;
        phase_d   = (phase_cnt == '1) ? phase_cnt : phase_cnt + PW'(1);
        timeout_d = timeout_cnt;
        ack_ok_d  = ack_ok;
        clk_oe_d  = ps2_clk_oe;
        data_oe_d = ps2_data_oe;
        done_d    = 1'b0;
        error_d   = 1'b0;

        if (state == SEND || state == ACK || state == WAIT_IDLE) begin
            if (fall) begin
                timeout_d = '0;
            end else if (timeout_cnt != '1) begin
                timeout_d = timeout_cnt + TW'(1);
            end
        end

        case (state)
            IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_valid && tx_ready) begin
                    frame_d  = {1'b1, ~^tx_data, tx_data};
                    phase_d  = '0;
                    clk_oe_d = 1'b1;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (phase_cnt == INHIBIT_LAST) begin
                    phase_d   = '0;
                    data_oe_d = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (phase_cnt == REQ_LAST) begin
                    clk_oe_d  = 1'b0;
                    bitcnt_d  = '0;
                    timeout_d = '0;
                    state_d   = SEND;
                end
            end
            SEND, ACK, WAIT_IDLE: begin
                if (!fall && timeout_cnt == TIMEOUT_LAST) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    error_d   = 1'b1;
                    state_d   = IDLE;
                end else if (state == SEND) begin
                    // Bit for the new count (bitcnt+1) sits at frame[bitcnt]: data LSB first, parity, stop.
                    if (fall) begin
                        bitcnt_d  = bitcnt + 4'd1;
                        data_oe_d = ~frame[bitcnt];
                        if (bitcnt == 4'd9) begin
                            state_d = ACK;
                        end
                    end
                end else if (state == ACK) begin
                    data_oe_d = 1'b0;
                    if (fall) begin
                        ack_ok_d = ~data_s;
                        state_d  = WAIT_IDLE;
                    end
                end else begin
                    data_oe_d = 1'b0;
                    if (ps2_clk_filtered && data_s) begin
                        done_d  = ack_ok;
                        error_d = ~ack_ok;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Bench for ps2_host_transmitter: a PS/2 device model clocks frames out of the DUT;
// expected frames and outcomes are queued at stimulus time and popped as the DUT produces them.
module tb_ps2_host_transmitter;

    localparam int INH = 20;
    localparam int REQ = 4;
    localparam int TMO = 200;
    localparam int FLT = 2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       ps2_clk_oe, ps2_data_oe, tx_ready, tx_done, tx_error, ps2_busy;
    logic       ps2_clk_in, ps2_data_in;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       glitch = 1'b0;
    logic       ps2_data_line;

    int         checks = 0;
    int         failures = 0;
    int         n;
    logic [9:0] b;
    logic [9:0] exp_frame_q[$];
    logic [1:0] exp_res_q[$];

    assign ps2_clk_in    = (~(ps2_clk_oe | dev_clk_low)) ^ glitch;
    assign ps2_data_line = ~(ps2_data_oe | dev_data_low);
    assign ps2_data_in   = ps2_data_line;

    always #5 clk = ~clk;

    ps2_host_transmitter #(
        .INHIBIT_CYCLES(INH),
        .REQ_CYCLES    (REQ),
        .TIMEOUT_CYCLES(TMO),
        .FILTER_LEN    (FLT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .tx_error   (tx_error),
        .ps2_busy   (ps2_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] frame_of(input logic [7:0] d);
        logic parity;
        parity = ($countones(d) % 2 == 0);
        return {1'b1, parity, d};
    endfunction

    // Result scoreboard: 2'b10 = done, 2'b01 = error.
    always @(negedge clk) begin
        if (tx_done || tx_error) begin
            if (exp_res_q.size() == 0)
                check("unexpected_pulse", {tx_done, tx_error}, 2'b00);
            else
                check("result", {tx_done, tx_error}, exp_res_q.pop_front());
        end
    end

    task automatic wait_neg(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic measure_request();
        int low = 0;
        int req = 0;
        while (ps2_clk_oe === 1'b1 && low < 1000) begin
            low++;
            if (ps2_data_oe) req++;
            @(negedge clk);
        end
        check("clk_low_len", low, INH + REQ);
        check("data_low_len", req, REQ);
        check("start_bit_held", ps2_data_oe, 1'b1);
    endtask

    task automatic request(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("accept_ready", tx_ready, 1'b0);
        check("accept_clk_oe", ps2_clk_oe, 1'b1);
        check("accept_busy", ps2_busy, 1'b1);
        measure_request();
    endtask

    task automatic half_period(input bit glitchy);
        repeat (9) @(negedge clk);
        if (glitchy) glitch = 1'b1;
        @(negedge clk);
        glitch = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic device_run(input int pulses, input bit do_ack, input bit glitchy, output logic [9:0] bits);
        bits = '0;
        wait_neg(20);
        for (int i = 1; i <= pulses; i++) begin
            if (i > 1) half_period(glitchy);
            if (i == 11 && do_ack) dev_data_low = 1'b1;
            dev_clk_low = 1'b1;
            half_period(glitchy);
            if (i <= 10) bits[i-1] = ps2_data_line;
            dev_clk_low = 1'b0;
        end
        dev_data_low = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        while (tx_ready !== 1'b1 && g < 1000) begin
            @(negedge clk);
            g++;
        end
        check("idle_reached", tx_ready, 1'b1);
        wait_neg(3);
    endtask

    task automatic send_ok(input logic [7:0] d, input bit do_ack);
        exp_frame_q.push_back(frame_of(d));
        exp_res_q.push_back(do_ack ? 2'b10 : 2'b01);
        request(d);
        device_run(11, do_ack, 1'b0, b);
        check("frame", b, exp_frame_q.pop_front());
        wait_idle();
    endtask

    initial begin
        wait_neg(3);
        check("rst_clk_oe", ps2_clk_oe, 1'b0);
        check("rst_data_oe", ps2_data_oe, 1'b0);
        check("rst_ready", tx_ready, 1'b1);
        check("rst_busy", ps2_busy, 1'b0);
        check("rst_pulses", {tx_done, tx_error}, 2'b00);
        reset_n = 1'b1;
        wait_neg(3);

        send_ok(8'hED, 1'b1);

        send_ok(8'h00, 1'b1);

        send_ok(8'hFF, 1'b0);

        // Device never clocks: error exactly TMO cycles after the clock release.
        exp_res_q.push_back(2'b01);
        request(8'hA5);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_error && n < 1000);
        check("timeout_cycles", n, TMO);
        check("timeout_clk_oe", ps2_clk_oe, 1'b0);
        check("timeout_data_oe", ps2_data_oe, 1'b0);
        @(negedge clk);
        check("timeout_idle", {ps2_clk_oe, ps2_data_oe, tx_ready}, 3'b001);
        wait_neg(5);

        // Reset after the 5th device fall; 0x81 bit 4 is 0, so data is being pulled low.
        request(8'h81);
        device_run(5, 1'b0, 1'b0, b);
        check("mid_data_oe_before", ps2_data_oe, 1'b1);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_clk_oe", ps2_clk_oe, 1'b0);
        check("mid_rst_data_oe", ps2_data_oe, 1'b0);
        check("mid_rst_ready", tx_ready, 1'b1);
        check("mid_rst_busy", ps2_busy, 1'b0);
        wait_neg(2);
        reset_n = 1'b1;
        wait_neg(5);
        send_ok(8'hF4, 1'b1);

        // Continuous tx_valid with glitches on the clock line.
        @(negedge clk);
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        exp_frame_q.push_back(frame_of(8'h5A));
        exp_res_q.push_back(2'b10);
        @(negedge clk);
        check("cont_accept_ready", tx_ready, 1'b0);
        check("cont_accept_clk_oe", ps2_clk_oe, 1'b1);
        tx_data = 8'h3C;
        measure_request();
        device_run(11, 1'b1, 1'b1, b);
        check("frame_glitchy", b, exp_frame_q.pop_front());
        n = 0;
        while (!tx_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("cont_done_seen", tx_done, 1'b1);
        check("cont_ready_in_done", tx_ready, 1'b1);
        exp_frame_q.push_back(frame_of(8'h3C));
        exp_res_q.push_back(2'b10);
        @(negedge clk);
        tx_valid = 1'b0;
        check("second_accept_ready", tx_ready, 1'b0);
        check("second_accept_clk_oe", ps2_clk_oe, 1'b1);
        measure_request();
        device_run(11, 1'b1, 1'b0, b);
        check("frame_second", b, exp_frame_q.pop_front());
        wait_idle();

        wait_neg(10);
        check("res_queue_drained", exp_res_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
